// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the 9-bit accumulator core instruction sequencer.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_HALT
  } seq_state_e;

  localparam int unsigned CNT_W = 16;

  // Instruction layout: inst[8] op class, inst[7:5] sub-op, inst[4:0] branch key.
  localparam logic [8:0] HALT_INST_DEF = 9'h1FF;
  localparam logic [3:0] OP_BRANCH     = 4'b1000;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_sequencer_branch_target_table.sv
// Branch target table: flop array, one synchronous write port, one combinational read port.
module branch_target_table #(
  parameter int unsigned KEY_W = 5,
  parameter int unsigned PC_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [KEY_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [KEY_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** KEY_W;

  logic [DEPTH-1:0][PC_W-1:0] tbl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tbl <= '0;
    else if (we) tbl[waddr] <= wdata;
  end

  // Read sees the pre-write contents when write and lookup hit the same key.
  assign rdata = tbl[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: owns the PC, steps FETCH -> EXEC (-> MEM_WAIT), gates commits.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned       PC_W      = 10,
  parameter int unsigned       INST_W    = 9,
  parameter int unsigned       KEY_W     = 5,
  parameter int unsigned       MEM_LAT   = 1,
  parameter logic [PC_W-1:0]   START_PC  = '0,
  parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_INST_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [PC_W-1:0]   pc_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] inst_o,
  input  logic              branch_en_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  output logic              commit_en,
  input  logic              tbl_we,
  input  logic [KEY_W-1:0]  tbl_addr,
  input  logic [PC_W-1:0]   tbl_data,
  output logic [CNT_W-1:0]  insn_count
);

  localparam bit         HAS_LAT   = (MEM_LAT != 0);
  localparam logic [2:0] WAIT_INIT = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

  seq_state_e      state;
  logic [2:0]      wait_cnt;
  logic [PC_W-1:0] tbl_rd;
  logic [PC_W-1:0] pc_next;
  logic            is_halt;
  logic            mem_stall;
  logic            commit;

  branch_target_table #(
    .KEY_W (KEY_W),
    .PC_W  (PC_W)
  ) u_btt (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (tbl_data),
    .raddr (inst_o[KEY_W-1:0]),
    .rdata (tbl_rd)
  );

  assign is_halt   = (inst_o == HALT_INST);
  assign mem_stall = HAS_LAT && (mem_rd_i || mem_wr_i);

  // commit_en qualifies the decoder's write enables for the instruction
  // currently in inst_o, so it must be valid in the same cycle; it is
  // decoded from state and forced low the instant reset returns state to IDLE.
  assign commit  = ((state == ST_EXEC) && !is_halt && !mem_stall) ||
                   ((state == ST_MEM_WAIT) && (wait_cnt == '0));
  assign commit_en = commit;

  assign pc_next = branch_en_i ? tbl_rd : pc_o + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc_o       <= '0;
      inst_o     <= '0;
      done       <= 1'b0;
      wait_cnt   <= '0;
      insn_count <= '0;
    end else begin
      if (commit) insn_count <= sat_inc(insn_count);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_FETCH;
            pc_o       <= START_PC;
            insn_count <= '0;
          end
        end
        ST_FETCH: begin
          inst_o <= inst_i;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_halt) begin
            state <= ST_HALT;
            done  <= 1'b1;
          end else if (mem_stall) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_MEM_WAIT;
          end else begin
            pc_o  <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_MEM_WAIT: begin
          if (wait_cnt == '0) begin
            pc_o  <= pc_next;
            state <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_HALT: begin
          if (start) begin
            state      <= ST_FETCH;
            pc_o       <= START_PC;
            done       <= 1'b0;
            insn_count <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one MEM_LAT=1 instance and one MEM_LAT=3 instance.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       tbl_we = 1'b0;
  logic [4:0] tbl_addr = '0;
  logic [9:0] tbl_data = '0;

  logic        start1 = 1'b0, done1, commit1, br1, rd1, wr1;
  logic [9:0]  pc1;
  logic [8:0]  inst_i1, inst_o1;
  logic [15:0] cnt1;
  logic        start3 = 1'b0, done3, commit3, br3, rd3, wr3;
  logic [9:0]  pc3;
  logic [8:0]  inst_i3, inst_o3;
  logic [15:0] cnt3;

  logic [8:0] rom1 [1024];
  logic [8:0] rom3 [1024];

  localparam logic [8:0] ALU_A = 9'h011;
  localparam logic [8:0] ALU_B = 9'h022;
  localparam logic [8:0] ALU_C = 9'h033;
  localparam logic [8:0] LD    = 9'h140;
  localparam logic [8:0] ST    = 9'h160;
  localparam logic [8:0] HALT  = 9'h1FF;

  function automatic logic [8:0] br_t(input logic [4:0] k);
    return {OP_BRANCH, k};
  endfunction
  function automatic logic [8:0] br_n(input logic [4:0] k);
    return {4'b1001, k};
  endfunction

  // Decoder model: {branch_en, mem_rd, mem_wr}
  function automatic logic [2:0] dec(input logic [8:0] i);
    if (i[8:5] == OP_BRANCH) return 3'b100;
    if (i[8:5] == 4'b1010)   return 3'b010;
    if (i[8:5] == 4'b1011)   return 3'b001;
    return 3'b000;
  endfunction

  assign inst_i1 = rom1[pc1];
  assign inst_i3 = rom3[pc3];
  assign {br1, rd1, wr1} = dec(inst_o1);
  assign {br3, rd3, wr3} = dec(inst_o3);

  instr_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .done(done1), .pc_o(pc1),
    .inst_i(inst_i1), .inst_o(inst_o1), .branch_en_i(br1), .mem_rd_i(rd1),
    .mem_wr_i(wr1), .commit_en(commit1), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .insn_count(cnt1)
  );

  instr_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .done(done3), .pc_o(pc3),
    .inst_i(inst_i3), .inst_o(inst_o3), .branch_en_i(br3), .mem_rd_i(rd3),
    .mem_wr_i(wr3), .commit_en(commit3), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .insn_count(cnt3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_roms();
    for (int i = 0; i < 1024; i++) begin
      rom1[i] = HALT;
      rom3[i] = HALT;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; tbl_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tbl_write(input logic [4:0] k, input logic [9:0] d);
    tbl_we = 1'b1; tbl_addr = k; tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  // Pulses start1, then waits (bounded) for done1; n = cycles taken or -1.
  task automatic run1(input int budget, output int n);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done1) n = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (pc1 !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h want=000", pc1); end
    checks++; if (inst_o1 !== 9'h000) begin failures++; $display("FAIL reset_inst got=%h want=000", inst_o1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done1); end
    checks++; if (commit1 !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b want=0", commit1); end
    checks++; if (cnt1 !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h want=0000", cnt1); end
    checks++; if (dut3.state !== ST_IDLE) begin failures++; $display("FAIL reset_state3 got=%0d want=IDLE", dut3.state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int exp_pc [7] = '{0, 0, 1, 1, 2, 2, 3};
    logic exp_c [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_roms();
    rom1[0] = ALU_A; rom1[1] = ALU_B; rom1[2] = ALU_C;
    do_reset();
    start1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (pc1 !== 10'(exp_pc[c])) begin failures++; $display("FAIL basic_pc cyc=%0d got=%h want=%h", c + 1, pc1, exp_pc[c]); end
      checks++; if (commit1 !== exp_c[c]) begin failures++; $display("FAIL basic_commit cyc=%0d got=%b want=%b", c + 1, commit1, exp_c[c]); end
    end
    @(negedge clk);
    checks++; if (commit1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL basic_halt_exec commit=%b done=%b want 0/0", commit1, done1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL basic_done got=%b want=1", done1); end
    checks++; if (pc1 !== 10'h003) begin failures++; $display("FAIL basic_halt_pc got=%h want=003", pc1); end
    checks++; if (cnt1 !== 16'd3) begin failures++; $display("FAIL basic_count got=%0d want=3", cnt1); end
  endtask

  task automatic test_branch();
    int n;
    clear_roms();
    rom1[0] = ALU_A; rom1[1] = ALU_B; rom1[2] = br_t(5'd5);
    do_reset();
    tbl_write(5'd5, 10'h040);
    run1(50, n);
    checks++; if (n < 0) begin failures++; $display("FAIL branch_taken_timeout got=no_done want=done"); end
    checks++; if (pc1 !== 10'h040) begin failures++; $display("FAIL branch_taken_pc got=%h want=040", pc1); end
    checks++; if (cnt1 !== 16'd3) begin failures++; $display("FAIL branch_taken_count got=%0d want=3", cnt1); end
    rom1[2] = br_n(5'd5);
    run1(50, n);
    checks++; if (n < 0) begin failures++; $display("FAIL branch_nt_timeout got=no_done want=done"); end
    checks++; if (pc1 !== 10'h003) begin failures++; $display("FAIL branch_nt_pc got=%h want=003", pc1); end
  endtask

  task automatic test_mem_latency();
    int exp_pc3 [6] = '{0, 0, 0, 0, 0, 1};
    logic exp_c3 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int exp_pc1 [4] = '{0, 0, 0, 1};
    logic exp_c1 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    clear_roms();
    rom3[0] = LD;
    rom1[0] = ST;
    do_reset();
    start3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      checks++; if (pc3 !== 10'(exp_pc3[c]) || commit3 !== exp_c3[c])
        begin failures++; $display("FAIL mem3 cyc=%0d pc=%h commit=%b want pc=%h commit=%b", c + 1, pc3, commit3, exp_pc3[c], exp_c3[c]); end
      if (c == 2) begin
        checks++; if (dut3.state !== ST_MEM_WAIT) begin failures++; $display("FAIL mem3_state got=%0d want=MEM_WAIT", dut3.state); end
      end
    end
    start1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (pc1 !== 10'(exp_pc1[c]) || commit1 !== exp_c1[c])
        begin failures++; $display("FAIL mem1 cyc=%0d pc=%h commit=%b want pc=%h commit=%b", c + 1, pc1, commit1, exp_pc1[c], exp_c1[c]); end
    end
  endtask

  task automatic test_wrap_sat();
    clear_roms();
    rom1[0] = br_t(5'd1);
    rom1[10'h3FF] = ALU_A;
    do_reset();
    tbl_write(5'd1, 10'h3FF);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc1 !== 10'h3FF) begin failures++; $display("FAIL wrap_top got=%h want=3ff", pc1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc1 !== 10'h000) begin failures++; $display("FAIL wrap_zero got=%h want=000", pc1); end
    checks++; if (cnt1 !== 16'd2) begin failures++; $display("FAIL wrap_count got=%0d want=2", cnt1); end
    force dut1.insn_count = 16'hFFFD;
    @(negedge clk);
    release dut1.insn_count;
    @(negedge clk);
    checks++; if (cnt1 !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe got=%h want=fffe", cnt1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cnt1 !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff got=%h want=ffff", cnt1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cnt1 !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", cnt1); end
    do_reset();
  endtask

  task automatic test_tbl_collision();
    int n;
    clear_roms();
    rom1[0] = br_t(5'd7);
    rom1[10'h010] = br_t(5'd7);
    do_reset();
    tbl_write(5'd7, 10'h010);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 5'd7; tbl_data = 10'h020;
    @(negedge clk);
    tbl_we = 1'b0;
    checks++; if (pc1 !== 10'h010) begin failures++; $display("FAIL coll_old got=%h want=010", pc1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc1 !== 10'h020) begin failures++; $display("FAIL coll_new got=%h want=020", pc1); end
    n = 0;
    while (!done1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (!done1) begin failures++; $display("FAIL coll_timeout got=no_done want=done"); end
    checks++; if (cnt1 !== 16'd2) begin failures++; $display("FAIL coll_count got=%0d want=2", cnt1); end
  endtask

  task automatic test_restart();
    clear_roms();
    rom3[0] = LD;
    rom1[0] = ALU_A; rom1[1] = ALU_B;
    do_reset();
    start3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    checks++; if (commit3 !== 1'b1) begin failures++; $display("FAIL rst_pre_commit got=%b want=1", commit3); end
    #2 reset = 1'b1;
    #1;
    checks++; if (commit3 !== 1'b0) begin failures++; $display("FAIL rst_async_commit got=%b want=0", commit3); end
    checks++; if (dut3.state !== ST_IDLE) begin failures++; $display("FAIL rst_async_state got=%0d want=IDLE", dut3.state); end
    checks++; if (inst_o3 !== 9'h000) begin failures++; $display("FAIL rst_async_inst got=%h want=000", inst_o3); end
    @(negedge clk);
    reset = 1'b0;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    checks++; if (pc1 !== 10'h001) begin failures++; $display("FAIL ign_start_exec got=%h want=001", pc1); end
    @(negedge clk);
    checks++; if (pc1 !== 10'h002) begin failures++; $display("FAIL ign_start_fetch got=%h want=002", pc1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (done1 !== 1'b1 || cnt1 !== 16'd2) begin failures++; $display("FAIL halt_state done=%b count=%0d want 1/2", done1, cnt1); end
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL restart_done got=%b want=0", done1); end
    checks++; if (pc1 !== 10'h000) begin failures++; $display("FAIL restart_pc got=%h want=000", pc1); end
    checks++; if (cnt1 !== 16'd0) begin failures++; $display("FAIL restart_count got=%0d want=0", cnt1); end
  endtask

  initial begin
    clear_roms();
    test_reset();
    test_basic();
    test_branch();
    test_mem_latency();
    test_wrap_sat();
    test_tbl_collision();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
